// File: rtl/quad_step_decoder.sv
// Quadrature decoder: sync + glitch filter per channel, Gray-code
// decode into a registered direction level and one-cycle step pulse.
module quad_step_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_a,
  input  logic i_b,
  input  logic i_clr_err,
  output logic o_up_down,
  output logic o_step,
  output logic o_err,
  output logic o_ready
);

  typedef enum logic {PRIME, RUN} state_t;

  localparam logic [3:0] FLEN  = 4'(FILTER_LEN);
  localparam logic [7:0] PLOAD = 8'(SYNC_STAGES + FILTER_LEN);

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic       s_a, s_b;
  logic       f_a, f_b;
  logic [3:0] cnt_a, cnt_b;
  logic [1:0] prv, cur;
  logic [7:0] prime_cnt;
  logic       run;
  logic       fwd, bwd, dbl;
  logic       step_nx, dir_nx, err_nx;

  assign s_a = sync_a[SYNC_STAGES-1];
  assign s_b = sync_b[SYNC_STAGES-1];
  assign run = (state == RUN);
  assign cur = {f_a, f_b};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], i_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], i_b};
    end
  end

  // Priming bypasses the filter so it starts aligned with the pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_a   <= 1'b0;
      cnt_a <= '0;
    end else if (!run) begin
      f_a   <= s_a;
      cnt_a <= '0;
    end else if (s_a == f_a) begin
      cnt_a <= '0;
    end else if (cnt_a + 4'd1 == FLEN) begin
      f_a   <= s_a;
      cnt_a <= '0;
    end else begin
      cnt_a <= cnt_a + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_b   <= 1'b0;
      cnt_b <= '0;
    end else if (!run) begin
      f_b   <= s_b;
      cnt_b <= '0;
    end else if (s_b == f_b) begin
      cnt_b <= '0;
    end else if (cnt_b + 4'd1 == FLEN) begin
      f_b   <= s_b;
      cnt_b <= '0;
    end else begin
      cnt_b <= cnt_b + 4'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prv       <= '0;
      prime_cnt <= PLOAD;
    end else begin
      prv <= cur;
      if (!run && prime_cnt != 8'd0)
        prime_cnt <= prime_cnt - 8'd1;
    end
  end

  assign fwd = (prv == 2'b00 && cur == 2'b01) ||
               (prv == 2'b01 && cur == 2'b11) ||
               (prv == 2'b11 && cur == 2'b10) ||
               (prv == 2'b10 && cur == 2'b00);
  assign bwd = (prv == 2'b00 && cur == 2'b10) ||
               (prv == 2'b10 && cur == 2'b11) ||
               (prv == 2'b11 && cur == 2'b01) ||
               (prv == 2'b01 && cur == 2'b00);
  assign dbl = ((prv ^ cur) == 2'b11);

  always_comb begin
    state_nx = state;
    step_nx  = 1'b0;
    dir_nx   = o_up_down;
    err_nx   = o_err;
    unique case (state)
      PRIME: begin
        if (prime_cnt == 8'd1)
          state_nx = RUN;
      end
      RUN: begin
        if (i_clr_err)
          err_nx = 1'b0;
        unique case (1'b1)
          fwd: begin
            step_nx = 1'b1;
            dir_nx  = 1'b1;
          end
          bwd: begin
            step_nx = 1'b1;
            dir_nx  = 1'b0;
          end
          dbl:     err_nx = 1'b1;
          default: ;
        endcase
      end
      default: state_nx = PRIME;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= PRIME;
      o_step    <= 1'b0;
      o_up_down <= 1'b1;
      o_err     <= 1'b0;
      o_ready   <= 1'b0;
    end else begin
      state     <= state_nx;
      o_step    <= step_nx;
      o_up_down <= dir_nx;
      o_err     <= err_nx;
      o_ready   <= (state_nx == RUN);
    end
  end

endmodule
